// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer: widths, opcodes, FSM states.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned OP_W   = 3;
  // Wait counter must hold LATENCY+1 with LATENCY up to 15.
  localparam int unsigned CNT_W  = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL   = 3'b010;
  localparam logic [OP_W-1:0] OP_SHIFT = 3'b011;
  localparam logic [OP_W-1:0] OP_OR    = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT   = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b110;
  localparam logic [OP_W-1:0] OP_NAND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq_wait_ctr.sv
// Down-counter timing the ALU settle window; done is high in the last wait cycle.
module alu_seq_wait_ctr
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Load on command accept, count down while waiting, stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_ONE;
    end
  end

  assign done = (count == CNT_ONE);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Single-command-in-flight sequencer: latches a command, drives an external ALU,
// waits for the result to settle, then presents a tagged response.
// Optional feature: define ALU_SEQ_FLAGS_EN to add the rsp_zero result flag.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_shift,
  output logic [OP_W-1:0]   alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_shift,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic [OP_W-1:0]   rsp_op,
  output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              rsp_zero
`endif
);

  seq_state_t       state;
  logic [TAG_W-1:0] tag_ctr;
  logic [TAG_W-1:0] cur_tag;
  logic [CNT_W-1:0] wait_len;
  logic             accept;
  logic             wait_done;

  assign accept = cmd_valid && cmd_ready;

  // The shifter is registered, so shift ops need one extra settle cycle.
  always_comb begin
    wait_len = CNT_W'(LATENCY);
    if (cmd_op == OP_SHIFT) begin
      wait_len = CNT_W'(LATENCY + 1);
    end
  end

  alu_seq_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (wait_len),
    .dec      (state == WAIT),
    .done     (wait_done)
  );

  // Sequencer FSM with all outputs registered; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_op    <= '0;
      rsp_tag   <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shift <= 1'b0;
      tag_ctr   <= '0;
      cur_tag   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_sel   <= cmd_op;
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_shift <= cmd_shift;
            cur_tag   <= tag_ctr;
            tag_ctr   <= tag_ctr + TAG_W'(1);
            cmd_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            rsp_data  <= alu_o;
            rsp_cout  <= alu_cout;
            rsp_op    <= alu_sel;
            rsp_tag   <= cur_tag;
            rsp_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero  <= (alu_o == '0);
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a settling ALU model.
module tb_alu_cmd_sequencer;

  localparam int unsigned LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_shift = 1'b0;
  logic [2:0] alu_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_shift;
  logic [7:0] alu_o;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_cout;
  logic [2:0] rsp_op;
  logic [3:0] rsp_tag;
`ifdef ALU_SEQ_FLAGS_EN
  logic       rsp_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_tag  = 0;

  alu_cmd_sequencer #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_shift (cmd_shift),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_shift (alu_shift),
    .alu_o     (alu_o),
    .alu_cout  (alu_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_op    (rsp_op),
    .rsp_tag   (rsp_tag)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Arithmetic meaning of each opcode: {carry, result}.
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic sh);
    logic [15:0] p;
    case (op)
      3'd0: ref_alu = {1'b0, a} + {1'b0, b};
      3'd1: ref_alu = {1'b0, a} - {1'b0, b};
      3'd2: begin p = a * b; ref_alu = {|p[15:8], p[7:0]}; end
      3'd3: ref_alu = sh ? {a[7], a[6:0], 1'b0} : {a[0], 1'b0, a[7:1]};
      3'd4: ref_alu = {1'b0, a | b};
      3'd5: ref_alu = {1'b0, ~a};
      3'd6: ref_alu = {1'b0, a ^ b};
      default: ref_alu = {1'b0, ~(a & b)};
    endcase
  endfunction

  // ALU model: result is only correct once inputs have been stable long
  // enough (LAT cycles, one more for shifts); before that it is inverted.
  logic [19:0] alu_last = '0;
  int          alu_age  = 0;
  always @(negedge clk) begin
    if ({alu_sel, alu_a, alu_b, alu_shift} != alu_last) alu_age = 1;
    else if (alu_age < 100) alu_age++;
    alu_last = {alu_sel, alu_a, alu_b, alu_shift};
  end
  always_comb begin
    logic [8:0] r;
    int need;
    r = ref_alu(alu_sel, alu_a, alu_b, alu_shift);
    need = (alu_sel == 3'd3) ? int'(LAT) + 1 : int'(LAT);
    if (alu_age >= need) {alu_cout, alu_o} = r;
    else                 {alu_cout, alu_o} = ~r;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Issue one command starting at a negedge with the DUT idle; returns at the
  // negedge after the response handshake (DUT idle again).
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sh, input int hold);
    logic [8:0] r;
    int n, c, start;
    r = ref_alu(op, a, b, sh);
    n = (op == 3'd3) ? int'(LAT) + 1 : int'(LAT);
    start = cyc;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_shift = sh;
    @(negedge clk);
    c = 1;
    while (!rsp_valid && c < 40) begin
      chk("alu_stable", 32'({alu_sel, alu_a, alu_b, alu_shift}), 32'({op, a, b, sh}));
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_a = 8'($urandom);
      cmd_b = 8'($urandom); cmd_shift = 1'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge clk);
      c++;
    end
    chk("rsp_latency", 32'(c), 32'(n + 1));
    chk("rsp_data", 32'(rsp_data), 32'(r[7:0]));
    chk("rsp_cout", 32'(rsp_cout), 32'(r[8]));
    chk("rsp_op", 32'(rsp_op), 32'(op));
    chk("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
`ifdef ALU_SEQ_FLAGS_EN
    chk("rsp_zero", 32'(rsp_zero), 32'(r[7:0] == 8'h00));
`endif
    chk("alu_stable_resp", 32'({alu_sel, alu_a, alu_b, alu_shift}), 32'({op, a, b, sh}));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp", 32'({rsp_data, rsp_cout, rsp_op, rsp_tag}),
          32'({r[7:0], r[8], op, 4'(exp_tag)}));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_alu", 32'({alu_sel, alu_a, alu_b, alu_shift}), 32'({op, a, b, sh}));
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("cycles_per_cmd", 32'(cyc - start), 32'(n + 2 + hold));
    exp_tag = (exp_tag + 1) % 16;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_cout, rsp_op, rsp_tag}), 32'd0);
    chk("rst_alu", 32'({alu_sel, alu_a, alu_b, alu_shift}), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_no_effect", 32'({cmd_ready, rsp_valid}), 32'b10);
    rsp_ready = 1'b0;

    do_cmd(3'd0, 8'h0F, 8'h01, 1'b0, 0);
    do_cmd(3'd3, 8'h81, 8'h00, 1'b1, 0);
    do_cmd(3'd1, 8'h10, 8'h20, 1'b0, 5);
    do_cmd(3'd6, 8'h5A, 8'h5A, 1'b0, 0);

    // Reset while a command waits for the ALU.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'h12; cmd_b = 8'h34; cmd_shift = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wait_rst_ready", 32'(cmd_ready), 32'd1);
    chk("wait_rst_rsp", 32'({rsp_valid, rsp_data, rsp_cout, rsp_op, rsp_tag}), 32'd0);
    chk("wait_rst_alu", 32'({alu_sel, alu_a, alu_b, alu_shift}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    exp_tag = 0;

    for (int i = 0; i < 17; i++) begin
      do_cmd(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    end
    for (int i = 0; i < 10; i++) begin
      do_cmd(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
